// File: rtl/seq_wide_adder.sv
// Multi-cycle wide adder: one byte pair per clock through fa8bit, LSB first. Optional signed
// overflow flag is compiled in when the OVERFLOW_FLAG_EN macro is defined.

// 8-bit ripple-carry adder.
// Latency: combinational.
// Backpressure: none.
module fa8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[8];
    end

endmodule

// Sequential NBYTES-wide adder built around fa8bit, carry chained through a register.
// Latency: start at E0, done high in the cycle after E(NBYTES); NBYTES+1 cycles per add.
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is dropped.
module seq_wide_adder #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic         ovf
`endif
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [W-1:0]    result_q;
    logic            cout_q;
    logic            accept;
    logic            last;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      fa_sum;
    logic            fa_cout;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (idx_q == IW'(NBYTES - 1));

    // Byte lane select from the captured operands.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                a_byte = a_q[i*8 +: 8];
                b_byte = b_q[i*8 +: 8];
            end
        end
    end

    fa8bit u_fa8bit (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // result is never cleared on start; bytes are overwritten in turn during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            carry_q <= fa_cout;
            idx_q   <= last ? '0 : idx_q + IW'(1);
            for (int i = 0; i < NBYTES; i++) begin
                if (idx_q == IW'(i)) begin
                    result_q[i*8 +: 8] <= fa_sum;
                end
            end
            if (last) begin
                cout_q <= fa_cout;
            end
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef OVERFLOW_FLAG_EN
    logic ovf_q;

    // fa_sum[7] on the final edge is the sign bit of the full result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (!accept && (state_q == RUN) && last) begin
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (fa_sum[7] != a_q[W-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
